rnd_uart_tx: RTL and testbench
==============================

RND_UART_TX -- requirements
Module: rnd_uart_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434, clock cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte-buffer entries; legal values are powers of 2, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic (50 MHz on board).
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port rnd_data, input, 8 bits: random byte from the STR TRNG core.
REQ-006 SHALL have port rnd_valid, input, 1 bit: rnd_data holds a new byte this cycle.
REQ-007 SHALL have port rnd_ready, output, 1 bit: block accepts a byte this cycle.
REQ-008 SHALL have port tx, output, 1 bit: UART serial line, 8N1, idle high, registered.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is not empty.
REQ-010 SHALL have port drop_cnt, output, 16 bits: saturating count of bytes lost because the FIFO was full.

Function
REQ-011 SHALL drive rnd_ready = not FIFO-full, combinationally from the registered FIFO count.
REQ-012 SHALL push rnd_data on a rising edge where rnd_valid and rnd_ready are both 1; no other condition pushes.
REQ-013 SHALL increment drop_cnt on each edge where rnd_valid=1 and rnd_ready=0, holding at 16'hFFFF (no wrap).
REQ-014 SHALL use an FSM with states IDLE, START, DATA, STOP and a baud counter counting 0..BAUD_DIV-1.
REQ-015 SHALL, in IDLE with the FIFO not empty: pop the head byte into the shift register, set tx=0, clear the baud counter and enter START, all on one edge.
REQ-016 SHALL, when the FIFO becomes non-empty at edge N while in IDLE, drive tx low after edge N+1 (one-cycle latency).
REQ-017 SHALL hold each bit (start, 8 data, stop) for exactly BAUD_DIV cycles, giving a frame of 10*BAUD_DIV cycles.
REQ-018 SHALL transmit data LSB first; the DATA state tracks bit index 0..7 with a 3-bit counter.
REQ-019 SHALL drive tx=1 for the stop bit.
REQ-020 SHALL, at the end of the stop bit, go directly to START (popping the next byte) if the FIFO is non-empty, with no idle gap; otherwise it SHALL go to IDLE.
REQ-021 SHALL allow a push and a pop on the same edge when the FIFO is not full; the count is unchanged and data order is preserved.
REQ-022 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; the count ranges 0..FIFO_DEPTH.
REQ-023 SHALL ignore rnd_data while rnd_valid=0; X on rnd_data SHALL then not propagate.
REQ-024 SHALL drive busy = (state != IDLE) or (count != 0).

Reset
REQ-025 SHALL, while rst=1, force: tx=1, state=IDLE, FIFO count and pointers=0, baud and bit counters=0, drop_cnt=0, busy=0.
REQ-026 SHALL hold rnd_ready=1 while rst=1, since the FIFO is not full; no push occurs while reset is held.
REQ-027 SHALL abort a frame on a mid-frame reset: tx returns to 1 immediately (asynchronously), and the partial byte and FIFO contents are discarded.
REQ-028 SHALL resume normal operation on the first edge after rst deasserts; no stray start bit is emitted.

Structure
REQ-029 SHALL place in shared package strng_pkg: the FSM state enum, the default BAUD_DIV constant and UART frame constants (DATA_BITS=8, FRAME_BITS=10).
REQ-030 SHALL implement the FIFO as sub-module rnd_fifo (synchronous, registered count, full/empty flags), instantiated once.
REQ-031 SHALL size the baud counter as clog2(BAUD_DIV) bits; it SHALL contain no other dividers or clock-enables.

Verification (BAUD_DIV=4, FIFO_DEPTH=4 unless stated)
REQ-032 SHALL cover: single push of 8'hA5 into an idle block -> tx low one cycle after the push, then bit pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy low after 40 cycles.
REQ-033 SHALL cover: rnd_valid held high for 10 cycles with bytes 0x00..0x09 -> rnd_ready drops once count=4; the first 5 bytes are transmitted back-to-back (a pop frees space) and drop_cnt equals the number of rejected cycles.
REQ-034 SHALL cover: pushing 6 bytes spaced 40 cycles apart -> six consecutive frames, with no idle gap between stop and start where the FIFO was non-empty.
REQ-035 SHALL cover: rst asserted at cycle 13 of a frame for 3 cycles -> tx=1 asynchronously, busy=0, drop_cnt=0, and no frame follows until a new push.
REQ-036 SHALL cover: drop_cnt preloaded near saturation (force 16'hFFFE) plus 3 rejected pushes -> drop_cnt = 16'hFFFF and stays there.
REQ-037 SHALL cover: a push coinciding with the pop at stop-bit end at count=1 -> count stays 1 and output order is correct.

Source files
------------

// File: rtl/strng_pkg.sv
// Shared types and constants for the TRNG byte-to-UART transmitter.
package strng_pkg;

    localparam int unsigned DEFAULT_BAUD_DIV = 434;
    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned FRAME_BITS       = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/rnd_fifo.sv
// Synchronous show-ahead byte FIFO with registered occupancy count.
module rnd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/rnd_uart_tx.sv
// Buffers TRNG bytes in a small FIFO and streams them out as 8N1 UART frames.
module rnd_uart_tx
    import strng_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rnd_data,
    input  logic        rnd_valid,
    output logic        rnd_ready,
    output logic        tx,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    uart_state_e          r_state;
    logic [BAUD_W-1:0]    r_baud_cnt;
    logic [BIT_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic [15:0]          r_drop_cnt;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_baud_end;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_fifo_data;

    assign w_baud_end = (r_baud_cnt == BAUD_W'(BAUD_DIV - 1));
    // A byte leaves the FIFO either from idle or straight out of a finished stop bit.
    assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));

    assign rnd_ready = !w_full;
    assign tx        = r_tx;
    assign busy      = (r_state != IDLE) || !w_empty;
    assign drop_cnt  = r_drop_cnt;

    rnd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (rnd_valid),
        .i_data  (rnd_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Frame sequencer: shift register is consumed LSB first, one bit per baud period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= w_fifo_data;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shift[0];
                        r_shift    <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_state    <= DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + BIT_W'(1);
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_fifo_data;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Saturating count of bytes offered while the FIFO was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (rnd_valid && w_full && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rnd_uart_tx.sv
// Self-checking bench for rnd_uart_tx against a frame-timer/queue reference model.
module tb_rnd_uart_tx;
    import strng_pkg::*;

    localparam int BAUD      = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = int'(FRAME_BITS) * BAUD;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rnd_data;
    logic        rnd_valid;
    logic        rnd_ready;
    logic        tx;
    logic        busy;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue plus cycles remaining in the current frame.
    logic [7:0]  m_q[$];
    logic [7:0]  m_cur = 8'h00;
    int          m_rem = 0;
    logic [15:0] m_drop = 16'h0000;
    logic        m_was_full;

    rnd_uart_tx #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .tx        (tx),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic m_tx();
        int k;
        if (m_rem == 0) return 1'b1;
        k = (FRAME_CYC - m_rem) / BAUD;
        if (k == 0) return 1'b0;
        if (k == int'(FRAME_BITS) - 1) return 1'b1;
        return m_cur[k-1];
    endfunction

    function automatic logic m_busy();
        return (m_rem != 0) || (m_q.size() != 0);
    endfunction

    function automatic logic m_ready();
        return m_q.size() < DEPTH;
    endfunction

    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            m_rem  = 0;
            m_drop = 16'h0000;
        end else begin
            m_was_full = (m_q.size() == DEPTH);
            if (m_rem <= 1 && m_q.size() != 0) begin
                m_cur = m_q.pop_front();
                m_rem = FRAME_CYC;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end
            if (rnd_valid && !m_was_full) m_q.push_back(rnd_data);
            else if (rnd_valid && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
    end

    task automatic test_reset();
        rst = 1'b1; rnd_valid = 1'b1; rnd_data = 8'h3C;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, busy, rnd_ready, drop_cnt} !== {1'b1, 1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL reset_hold: tx/busy/rdy/drop=%b/%b/%b/%h want 1/0/1/0000", tx, busy, rnd_ready, drop_cnt);
        end
        rnd_valid = 1'b0; rnd_data = 'x;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({tx, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: tx/busy=%b/%b want 1/0", tx, busy);
        end
    endtask

    task automatic test_single();
        logic [9:0] pat = 10'b1101001010;
        @(negedge clk); rnd_valid = 1'b1; rnd_data = 8'hA5;
        @(negedge clk); rnd_valid = 1'b0; rnd_data = 'x;
        checks++;
        if ({tx, busy} !== 2'b11) begin
            errors++;
            $display("FAIL single_latency: tx/busy=%b/%b want 1/1", tx, busy);
        end
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== pat[i/BAUD]) begin
                errors++;
                $display("FAIL single_bit cyc%0d: tx=%b want %b", i, tx, pat[i/BAUD]);
            end
            checks++;
            if ({tx, busy, rnd_ready, drop_cnt} !== {m_tx(), m_busy(), m_ready(), m_drop}) begin
                errors++;
                $display("FAIL single_model t=%0t: tx/busy/rdy/drop=%b/%b/%b/%h want %b/%b/%b/%h",
                         $time, tx, busy, rnd_ready, drop_cnt, m_tx(), m_busy(), m_ready(), m_drop);
            end
        end
        @(negedge clk);
        checks++;
        if ({tx, busy} !== 2'b10) begin
            errors++;
            $display("FAIL single_done: tx/busy=%b/%b want 1/0", tx, busy);
        end
    endtask

    task automatic test_burst();
        logic [15:0] base = m_drop;
        int first_low = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, rnd_ready, drop_cnt} !== {m_tx(), m_busy(), m_ready(), m_drop}) begin
                errors++;
                $display("FAIL burst_in t=%0t: tx/busy/rdy/drop=%b/%b/%b/%h want %b/%b/%b/%h",
                         $time, tx, busy, rnd_ready, drop_cnt, m_tx(), m_busy(), m_ready(), m_drop);
            end
            if (!rnd_ready && first_low < 0) first_low = i;
            rnd_valid = 1'b1; rnd_data = 8'(i);
        end
        @(negedge clk); rnd_valid = 1'b0; rnd_data = 'x;
        checks++;
        if (drop_cnt !== base + 16'd5) begin
            errors++;
            $display("FAIL burst_drop: drop=%h want %h", drop_cnt, base + 16'd5);
        end
        checks++;
        if (first_low !== 5) begin
            errors++;
            $display("FAIL burst_ready: ready first low at byte %0d want 5", first_low);
        end
        for (int n = 0; n < 400 && (busy !== 1'b0 || m_busy()); n++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, rnd_ready, drop_cnt} !== {m_tx(), m_busy(), m_ready(), m_drop}) begin
                errors++;
                $display("FAIL burst_drain t=%0t: tx/busy/rdy/drop=%b/%b/%b/%h want %b/%b/%b/%h",
                         $time, tx, busy, rnd_ready, drop_cnt, m_tx(), m_busy(), m_ready(), m_drop);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_idle: busy=%b want 0 after drain budget", busy);
        end
    endtask

    task automatic test_spaced();
        bit gap = 1'b0;
        for (int k = 0; k < 6; k++) begin
            rnd_valid = 1'b1; rnd_data = 8'($urandom);
            for (int c = 0; c < FRAME_CYC; c++) begin
                @(negedge clk);
                rnd_valid = 1'b0; rnd_data = 'x;
                checks++;
                if ({tx, busy, rnd_ready, drop_cnt} !== {m_tx(), m_busy(), m_ready(), m_drop}) begin
                    errors++;
                    $display("FAIL spaced_model t=%0t: tx/busy/rdy/drop=%b/%b/%b/%h want %b/%b/%b/%h",
                             $time, tx, busy, rnd_ready, drop_cnt, m_tx(), m_busy(), m_ready(), m_drop);
                end
                if (busy !== 1'b1) gap = 1'b1;
            end
        end
        checks++;
        if (gap) begin
            errors++;
            $display("FAIL spaced_gap: busy dropped between frames, got gap=1 want 0");
        end
        for (int n = 0; n < 200 && (busy !== 1'b0 || m_busy()); n++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy} !== {m_tx(), m_busy()}) begin
                errors++;
                $display("FAIL spaced_drain t=%0t: tx/busy=%b/%b want %b/%b", $time, tx, busy, m_tx(), m_busy());
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL spaced_idle: busy=%b want 0 after drain budget", busy);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] b = 8'($urandom) & 8'hFB;
        @(negedge clk); rnd_valid = 1'b1; rnd_data = b;
        @(negedge clk); rnd_valid = 1'b0; rnd_data = 'x;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy} !== {m_tx(), m_busy()}) begin
                errors++;
                $display("FAIL midrst_frame cyc%0d: tx/busy=%b/%b want %b/%b", c, tx, busy, m_tx(), m_busy());
            end
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: tx=%b want 0 (data bit2 of %h)", tx, b);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({tx, busy, drop_cnt} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL midrst_async: tx/busy/drop=%b/%b/%h want 1/0/0000", tx, busy, drop_cnt);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, rnd_ready} !== 3'b101) begin
                errors++;
                $display("FAIL midrst_quiet cyc%0d: tx/busy/rdy=%b/%b/%b want 1/0/1", c, tx, busy, rnd_ready);
            end
        end
    endtask

    task automatic test_same_edge();
        @(negedge clk); rnd_valid = 1'b1; rnd_data = 8'($urandom);
        @(negedge clk); rnd_valid = 1'b0; rnd_data = 'x;
        repeat (5) @(negedge clk);
        rnd_valid = 1'b1; rnd_data = 8'($urandom);
        @(negedge clk); rnd_valid = 1'b0; rnd_data = 'x;
        for (int n = 0; n < 60 && m_rem != 1; n++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, rnd_ready} !== {m_tx(), m_busy(), m_ready()}) begin
                errors++;
                $display("FAIL same_edge_wait t=%0t: tx/busy/rdy=%b/%b/%b want %b/%b/%b",
                         $time, tx, busy, rnd_ready, m_tx(), m_busy(), m_ready());
            end
        end
        checks++;
        if (dut.u_fifo.r_count !== 3'd1) begin
            errors++;
            $display("FAIL same_edge_pre: count=%0d want 1", dut.u_fifo.r_count);
        end
        rnd_valid = 1'b1; rnd_data = 8'($urandom);
        @(negedge clk); rnd_valid = 1'b0; rnd_data = 'x;
        checks++;
        if (dut.u_fifo.r_count !== 3'd1) begin
            errors++;
            $display("FAIL same_edge_count: count=%0d want 1", dut.u_fifo.r_count);
        end
        checks++;
        if ({tx, busy} !== 2'b01) begin
            errors++;
            $display("FAIL same_edge_start: tx/busy=%b/%b want 0/1", tx, busy);
        end
        for (int n = 0; n < 200 && (busy !== 1'b0 || m_busy()); n++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy} !== {m_tx(), m_busy()}) begin
                errors++;
                $display("FAIL same_edge_order t=%0t: tx/busy=%b/%b want %b/%b", $time, tx, busy, m_tx(), m_busy());
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_idle: busy=%b want 0 after drain budget", busy);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, rnd_ready, drop_cnt} !== {m_tx(), m_busy(), m_ready(), m_drop}) begin
                errors++;
                $display("FAIL random t=%0t: tx/busy/rdy/drop=%b/%b/%b/%h want %b/%b/%b/%h",
                         $time, tx, busy, rnd_ready, drop_cnt, m_tx(), m_busy(), m_ready(), m_drop);
            end
            rnd_valid = ($urandom_range(0, (c < 200) ? 3 : 40) == 0);
            rnd_data  = rnd_valid ? 8'($urandom) : 8'hxx;
        end
        @(negedge clk); rnd_valid = 1'b0; rnd_data = 'x;
        for (int n = 0; n < 400 && (busy !== 1'b0 || m_busy()); n++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, rnd_ready, drop_cnt} !== {m_tx(), m_busy(), m_ready(), m_drop}) begin
                errors++;
                $display("FAIL random_drain t=%0t: tx/busy/rdy/drop=%b/%b/%b/%h want %b/%b/%b/%h",
                         $time, tx, busy, rnd_ready, drop_cnt, m_tx(), m_busy(), m_ready(), m_drop);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL random_idle: busy=%b want 0 after drain budget", busy);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) begin
            rnd_valid = 1'b1; rnd_data = 8'($urandom);
            @(negedge clk);
        end
        rnd_valid = 1'b0; rnd_data = 'x;
        checks++;
        if (rnd_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_full: rdy=%b want 0", rnd_ready);
        end
        force dut.r_drop_cnt = 16'hFFFE;
        m_drop = 16'hFFFE;
        #1;
        release dut.r_drop_cnt;
        checks++;
        if (drop_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_preload: drop=%h want fffe", drop_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rnd_valid = 1'b1; rnd_data = 8'($urandom);
            @(negedge clk);
            rnd_valid = 1'b0; rnd_data = 'x;
            checks++;
            if (drop_cnt !== 16'hFFFF) begin
                errors++;
                $display("FAIL sat_hold rej%0d: drop=%h want ffff", i, drop_cnt);
            end
            checks++;
            if ({tx, busy, rnd_ready, drop_cnt} !== {m_tx(), m_busy(), m_ready(), m_drop}) begin
                errors++;
                $display("FAIL sat_model t=%0t: tx/busy/rdy/drop=%b/%b/%b/%h want %b/%b/%b/%h",
                         $time, tx, busy, rnd_ready, drop_cnt, m_tx(), m_busy(), m_ready(), m_drop);
            end
        end
        for (int n = 0; n < 400 && (busy !== 1'b0 || m_busy()); n++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, drop_cnt} !== {m_tx(), m_busy(), m_drop}) begin
                errors++;
                $display("FAIL sat_drain t=%0t: tx/busy/drop=%b/%b/%h want %b/%b/%h",
                         $time, tx, busy, drop_cnt, m_tx(), m_busy(), m_drop);
            end
        end
        checks++;
        if ({busy, drop_cnt} !== {1'b0, 16'hFFFF}) begin
            errors++;
            $display("FAIL sat_end: busy/drop=%b/%h want 0/ffff", busy, drop_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; rnd_valid = 1'b0; rnd_data = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_spaced();
        test_mid_reset();
        test_same_edge();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
